shifter_operand_unit: RTL and testbench

//  Data-processing operand-2 generator for the execute stage: rotated 8-bit immediate, immediate-shifted Rm,

---
 rtl/shifter_operand_unit_pkg.sv | 18 +
 rtl/shifter_operand_unit_core.sv | 102 ++++++++++
 rtl/shifter_operand_unit.sv | 127 ++++++++++++
 tb/tb_shifter_operand_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_operand_unit_pkg.sv
// Shared encodings for the operand-2 shifter: operand select, shift type and control states.
package shifter_operand_unit_pkg;

    localparam logic [1:0] SEL_IMM_ROT   = 2'b00;
    localparam logic [1:0] SEL_IMM_SHIFT = 2'b01;
    localparam logic [1:0] SEL_REG_SHIFT = 2'b10;
    localparam logic [1:0] SEL_PASS      = 2'b11;

    localparam logic [1:0] SHIFT_LSL = 2'b00;
    localparam logic [1:0] SHIFT_LSR = 2'b01;
    localparam logic [1:0] SHIFT_ASR = 2'b10;
    localparam logic [1:0] SHIFT_ROR = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_EXTRA = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b10;

endpackage

// File: rtl/shifter_operand_unit_core.sv
// Combinational ARM-style barrel shifter producing operand 2 and the shifter carry-out.
module shifter_operand_unit_core
    import shifter_operand_unit_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic [1:0]            sel,
    input  logic [1:0]            shift_type,
    input  logic [7:0]            imm8,
    input  logic [3:0]            rotate_imm,
    input  logic [SHAMT_W-1:0]    shift_imm,
    input  logic [7:0]            amount,
    input  logic [DATA_WIDTH-1:0] rm,
    input  logic                  c_in,
    output logic [DATA_WIDTH-1:0] operand,
    output logic                  carry
);

    function automatic logic [DATA_WIDTH-1:0] ror_f(input logic [DATA_WIDTH-1:0] x,
                                                    input logic [SHAMT_W-1:0]    n);
        return DATA_WIDTH'({x, x} >> n);
    endfunction

    logic [SHAMT_W-1:0]    rot_amt_s;
    logic [SHAMT_W-1:0]    n_s;
    logic [DATA_WIDTH-1:0] imm_ext_s;
    logic [DATA_WIDTH-1:0] lsl_s, lsr_s, asr_s, ror_s, fill_s;
    logic                  msb_s, c_hi_s, c_lo_s;
    logic                  amt_zero_s, amt_lt_w_s, amt_eq_w_s;

    // Register shifts reuse the same barrel; amounts >= W are handled by the compare flags.
    assign rot_amt_s  = SHAMT_W'({rotate_imm, 1'b0});
    assign n_s        = (sel == SEL_REG_SHIFT) ? SHAMT_W'(amount) : shift_imm;
    assign imm_ext_s  = {{(DATA_WIDTH-8){1'b0}}, imm8};
    assign lsl_s      = rm << n_s;
    assign lsr_s      = rm >> n_s;
    assign asr_s      = $signed(rm) >>> n_s;
    assign ror_s      = ror_f(rm, n_s);
    assign msb_s      = rm[DATA_WIDTH-1];
    assign fill_s     = {DATA_WIDTH{msb_s}};
    assign c_hi_s     = rm[{SHAMT_W{1'b0}} - n_s];
    assign c_lo_s     = rm[n_s - {{(SHAMT_W-1){1'b0}}, 1'b1}];
    assign amt_zero_s = (amount == 8'd0);
    assign amt_lt_w_s = ({24'd0, amount} < 32'(DATA_WIDTH));
    assign amt_eq_w_s = ({24'd0, amount} == 32'(DATA_WIDTH));

    // Operand/carry selection following the ARM shifter-operand rules.
    always_comb begin
        operand = rm;
        carry   = c_in;
        case (sel)
            SEL_IMM_ROT: begin
                operand = ror_f(imm_ext_s, rot_amt_s);
                if (rotate_imm == 4'd0) carry = c_in;
                else                    carry = operand[DATA_WIDTH-1];
            end
            SEL_IMM_SHIFT: begin
                case (shift_type)
                    SHIFT_LSL: if (n_s == '0) begin operand = rm;              carry = c_in;  end
                               else           begin operand = lsl_s;           carry = c_hi_s; end
                    SHIFT_LSR: if (n_s == '0) begin operand = '0;              carry = msb_s; end
                               else           begin operand = lsr_s;           carry = c_lo_s; end
                    SHIFT_ASR: if (n_s == '0) begin operand = fill_s;          carry = msb_s; end
                               else           begin operand = asr_s;           carry = c_lo_s; end
                    SHIFT_ROR: if (n_s == '0) begin operand = {c_in, rm[DATA_WIDTH-1:1]}; carry = rm[0]; end
                               else           begin operand = ror_s;           carry = c_lo_s; end
                    default:   begin operand = rm; carry = c_in; end
                endcase
            end
            SEL_REG_SHIFT: begin
                if (amt_zero_s) begin
                    operand = rm;
                    carry   = c_in;
                end else begin
                    case (shift_type)
                        SHIFT_LSL: if (amt_lt_w_s)      begin operand = lsl_s; carry = c_hi_s; end
                                   else if (amt_eq_w_s) begin operand = '0;    carry = rm[0];  end
                                   else                 begin operand = '0;    carry = 1'b0;   end
                        SHIFT_LSR: if (amt_lt_w_s)      begin operand = lsr_s; carry = c_lo_s; end
                                   else if (amt_eq_w_s) begin operand = '0;    carry = msb_s;  end
                                   else                 begin operand = '0;    carry = 1'b0;   end
                        SHIFT_ASR: if (amt_lt_w_s)      begin operand = asr_s;  carry = c_lo_s; end
                                   else                 begin operand = fill_s; carry = msb_s;  end
                        SHIFT_ROR: if (n_s == '0)       begin operand = rm;     carry = msb_s;  end
                                   else                 begin operand = ror_s;  carry = c_lo_s; end
                        default:   begin operand = rm; carry = c_in; end
                    endcase
                end
            end
            SEL_PASS: begin
                operand = rm;
                carry   = c_in;
            end
            default: begin
                operand = rm;
                carry   = c_in;
            end
        endcase
    end

endmodule

// File: rtl/shifter_operand_unit.sv
// Execute-stage operand-2 generator: handshake FSM, Rs-read capture register and registered result.
module shifter_operand_unit
    import shifter_operand_unit_pkg::*;
#(
    parameter  int DATA_WIDTH        = 32,
    parameter  int REG_SHIFT_LATENCY = 1,
    localparam int SHAMT_W           = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            sel,
    input  logic [1:0]            shift_type,
    input  logic [7:0]            imm8,
    input  logic [3:0]            rotate_imm,
    input  logic [SHAMT_W-1:0]    shift_imm,
    input  logic [DATA_WIDTH-1:0] rm,
    input  logic [DATA_WIDTH-1:0] rs,
    input  logic                  c_flag_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] shifter_operand,
    output logic                  shifter_carry_out
);

    logic [1:0]            state_r;
    logic [1:0]            cap_type_r;
    logic [7:0]            cap_amt_r;
    logic [DATA_WIDTH-1:0] cap_rm_r;
    logic                  cap_c_r;

    logic [1:0]            core_sel_s, core_type_s;
    logic [7:0]            core_amt_s;
    logic [DATA_WIDTH-1:0] core_rm_s, core_op_s;
    logic                  core_c_s, core_carry_s;
    logic                  accept_s, defer_s, unused_rs_s;

    // Only the low byte of Rs is a shift amount.
    assign unused_rs_s = ^rs[DATA_WIDTH-1:8];
    assign in_ready    = (state_r == ST_IDLE) || ((state_r == ST_FULL) && out_ready);
    assign accept_s    = in_valid && in_ready;
    assign defer_s     = (sel == SEL_REG_SHIFT) && (REG_SHIFT_LATENCY == 1);

    // Core sees the captured register-shift request while in EXTRA, live inputs otherwise.
    always_comb begin
        core_sel_s  = sel;
        core_type_s = shift_type;
        core_amt_s  = rs[7:0];
        core_rm_s   = rm;
        core_c_s    = c_flag_in;
        if (state_r == ST_EXTRA) begin
            core_sel_s  = SEL_REG_SHIFT;
            core_type_s = cap_type_r;
            core_amt_s  = cap_amt_r;
            core_rm_s   = cap_rm_r;
            core_c_s    = cap_c_r;
        end else begin
            core_sel_s  = sel;
            core_type_s = shift_type;
            core_amt_s  = rs[7:0];
            core_rm_s   = rm;
            core_c_s    = c_flag_in;
        end
    end

    shifter_operand_unit_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
        .sel        (core_sel_s),
        .shift_type (core_type_s),
        .imm8       (imm8),
        .rotate_imm (rotate_imm),
        .shift_imm  (shift_imm),
        .amount     (core_amt_s),
        .rm         (core_rm_s),
        .c_in       (core_c_s),
        .operand    (core_op_s),
        .carry      (core_carry_s)
    );

    // Handshake FSM, capture register and output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r           <= ST_IDLE;
            out_valid         <= 1'b0;
            shifter_operand   <= '0;
            shifter_carry_out <= 1'b0;
            cap_type_r        <= 2'b00;
            cap_amt_r         <= 8'd0;
            cap_rm_r          <= '0;
            cap_c_r           <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_FULL: begin
                    if (accept_s) begin
                        if (defer_s) begin
                            state_r    <= ST_EXTRA;
                            out_valid  <= 1'b0;
                            cap_type_r <= shift_type;
                            cap_amt_r  <= rs[7:0];
                            cap_rm_r   <= rm;
                            cap_c_r    <= c_flag_in;
                        end else begin
                            state_r           <= ST_FULL;
                            out_valid         <= 1'b1;
                            shifter_operand   <= core_op_s;
                            shifter_carry_out <= core_carry_s;
                        end
                    end else if ((state_r == ST_FULL) && out_ready) begin
                        state_r   <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                ST_EXTRA: begin
                    state_r           <= ST_FULL;
                    out_valid         <= 1'b1;
                    shifter_operand   <= core_op_s;
                    shifter_carry_out <= core_carry_s;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shifter_operand_unit.sv
// Directed and random checks of shifter_operand_unit against a bit-serial ARM shifter model.
module tb_shifter_operand_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  sel, shift_type;
    logic [7:0]  imm8;
    logic [3:0]  rotate_imm;
    logic [4:0]  shift_imm;
    logic [31:0] rm, rs, shifter_operand;
    logic        c_flag_in, shifter_carry_out;

    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b;
    logic [1:0]  sel_b, shift_type_b;
    logic [7:0]  imm8_b;
    logic [3:0]  rotate_imm_b, shift_imm_b;
    logic [15:0] rm_b, rs_b, shifter_operand_b;
    logic        c_flag_in_b, shifter_carry_out_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shifter_operand_unit #(.DATA_WIDTH(32), .REG_SHIFT_LATENCY(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .shift_type(shift_type), .imm8(imm8), .rotate_imm(rotate_imm),
        .shift_imm(shift_imm), .rm(rm), .rs(rs), .c_flag_in(c_flag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .shifter_operand(shifter_operand), .shifter_carry_out(shifter_carry_out)
    );

    shifter_operand_unit #(.DATA_WIDTH(16), .REG_SHIFT_LATENCY(0)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .sel(sel_b), .shift_type(shift_type_b), .imm8(imm8_b), .rotate_imm(rotate_imm_b),
        .shift_imm(shift_imm_b), .rm(rm_b), .rs(rs_b), .c_flag_in(c_flag_in_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .shifter_operand(shifter_operand_b), .shifter_carry_out(shifter_carry_out_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-bit-at-a-time shifter; carry is the last bit shifted out.
    function automatic logic [32:0] steps(input logic [1:0] t, input logic [31:0] v0,
                                          input logic c0, input int n);
        logic [31:0] v;
        logic        cy;
        v  = v0;
        cy = c0;
        for (int k = 0; k < n; k++) begin
            case (t)
                2'd0:    begin cy = v[31]; v = {v[30:0], 1'b0}; end
                2'd1:    begin cy = v[0];  v = {1'b0, v[31:1]}; end
                2'd2:    begin cy = v[0];  v = {v[31], v[31:1]}; end
                default: begin cy = v[0];  v = {v[0], v[31:1]}; end
            endcase
        end
        return {cy, v};
    endfunction

    function automatic logic [32:0] ref_model(input logic [1:0] s, input logic [1:0] t,
                                              input logic [7:0] i8, input logic [3:0] ri,
                                              input logic [4:0] sh, input logic [31:0] r,
                                              input logic [31:0] rsv, input logic c);
        logic [32:0] res;
        case (s)
            2'd0: begin
                res = steps(2'd3, {24'd0, i8}, c, 2 * int'(ri));
                res[32] = (ri == 4'd0) ? c : res[31];
            end
            2'd1: begin
                if (sh != 5'd0)    res = steps(t, r, c, int'(sh));
                else if (t == 2'd0) res = {c, r};
                else if (t == 2'd3) res = {r[0], c, r[31:1]};
                else               res = steps(t, r, c, 32);
            end
            2'd2:    res = steps(t, r, c, int'(rsv[7:0]));
            default: res = {c, r};
        endcase
        return res;
    endfunction

    task automatic do_req(input string tag, input logic [1:0] s, input logic [1:0] t,
                          input logic [7:0] i8, input logic [3:0] ri, input logic [4:0] sh,
                          input logic [31:0] r, input logic [31:0] rsv, input logic c,
                          input logic [31:0] eop, input logic ec, input int elat);
        int cyc;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        sel = s; shift_type = t; imm8 = i8; rotate_imm = ri; shift_imm = sh;
        rm = r; rs = rsv; c_flag_in = c;
        in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        // Scramble live inputs so only the sampled values may matter.
        rm = $urandom; rs = $urandom; c_flag_in = ~c; sel = 2'(~s); shift_type = 2'(~t);
        cyc = 1;
        if (elat == 2) chk({tag, "_extra_block"}, 64'(in_ready), 64'd0);
        while (!out_valid && cyc < 6) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(elat));
        chk({tag, "_op"}, 64'(shifter_operand), 64'(eop));
        chk({tag, "_carry"}, 64'(shifter_carry_out), 64'(ec));
        @(negedge clk);
        chk({tag, "_stall_hold"}, 64'({out_valid, shifter_carry_out, shifter_operand}),
            64'({1'b1, ec, eop}));
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_retired"}, 64'(out_valid), 64'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32:0] q[$];
        logic [32:0] expv[4];
        logic [1:0]  bs[4], bt[4];
        logic [7:0]  bi8[4];
        logic [3:0]  bri[4];
        logic [4:0]  bsh[4];
        logic [31:0] brm[4];
        logic        bc[4];
        int          pat[4];
        int          sent, got;
        logic        acc, ret;
        logic [1:0]  rs_sel, rt;
        logic [31:0] rr, rsr;
        logic [32:0] e;

        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; sel = 2'd0; shift_type = 2'd0; imm8 = 8'd0;
        rotate_imm = 4'd0; shift_imm = 5'd0; rm = 32'd0; rs = 32'd0; c_flag_in = 1'b0;
        in_valid_b = 1'b0; out_ready_b = 1'b0; sel_b = 2'd0; shift_type_b = 2'd0; imm8_b = 8'd0;
        rotate_imm_b = 4'd0; shift_imm_b = 4'd0; rm_b = 16'd0; rs_b = 16'd0; c_flag_in_b = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_state", 64'({out_valid, shifter_carry_out, shifter_operand}), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        // Reset during EXTRA discards the request.
        sel = 2'd2; shift_type = 2'd0; rm = 32'd1; rs = 32'd32; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_extra_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("reset_discard_0", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("reset_discard_1", 64'(out_valid), 64'd0);
        chk("post_reset_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b0;

        do_req("imm_rot4", 2'd0, 2'd0, 8'hFF, 4'd4, 5'd0, 32'd0, 32'd0, 1'b0, 32'hFF000000, 1'b1, 1);
        do_req("imm_rot0", 2'd0, 2'd0, 8'hFF, 4'd0, 5'd0, 32'd0, 32'd0, 1'b1, 32'h000000FF, 1'b1, 1);
        do_req("lsr_n0", 2'd1, 2'd1, 8'd0, 4'd0, 5'd0, 32'h80000001, 32'd0, 1'b0, 32'd0, 1'b1, 1);
        do_req("asr_n0", 2'd1, 2'd2, 8'd0, 4'd0, 5'd0, 32'h80000001, 32'd0, 1'b0, 32'hFFFFFFFF, 1'b1, 1);
        do_req("rrx", 2'd1, 2'd3, 8'd0, 4'd0, 5'd0, 32'h80000001, 32'd0, 1'b0, 32'h40000000, 1'b1, 1);
        do_req("reg_lsl32", 2'd2, 2'd0, 8'd0, 4'd0, 5'd0, 32'd1, 32'd32, 1'b0, 32'd0, 1'b1, 2);
        do_req("reg_lsl33", 2'd2, 2'd0, 8'd0, 4'd0, 5'd0, 32'd1, 32'd33, 1'b1, 32'd0, 1'b0, 2);
        do_req("reg_ror64", 2'd2, 2'd3, 8'd0, 4'd0, 5'd0, 32'd1, 32'd64, 1'b1, 32'd1, 1'b0, 2);
        do_req("pass", 2'd3, 2'd1, 8'd0, 4'd0, 5'd7, 32'hCAFEF00D, 32'd5, 1'b1, 32'hCAFEF00D, 1'b1, 1);

        for (int i = 0; i < 40; i++) begin
            rs_sel = 2'($urandom_range(0, 3));
            rt     = 2'($urandom_range(0, 3));
            rr     = $urandom;
            rsr    = $urandom;
            case ($urandom_range(0, 2))
                0:       rsr[7:0] = 8'($urandom_range(0, 40));
                1:       rsr[7:0] = 8'($urandom_range(28, 36));
                default: rsr[7:0] = 8'($urandom_range(60, 255));
            endcase
            imm8 = 8'($urandom); rotate_imm = 4'($urandom); shift_imm = 5'($urandom);
            c_flag_in = 1'($urandom);
            if (i % 5 == 0) shift_imm = 5'd0;
            e = ref_model(rs_sel, rt, imm8, rotate_imm, shift_imm, rr, rsr, c_flag_in);
            do_req("rand", rs_sel, rt, imm8, rotate_imm, shift_imm, rr, rsr, c_flag_in,
                   e[31:0], e[32], (rs_sel == 2'd2) ? 2 : 1);
        end

        // Back-to-back immediates under out_ready pattern 1,0,0,1.
        pat = '{1, 0, 0, 1};
        for (int k = 0; k < 4; k++) begin
            bs[k] = (k % 2 == 0) ? 2'd0 : 2'd1;
            bt[k] = 2'($urandom); bi8[k] = 8'($urandom); bri[k] = 4'($urandom);
            bsh[k] = 5'($urandom); brm[k] = $urandom; bc[k] = 1'($urandom);
            expv[k] = ref_model(bs[k], bt[k], bi8[k], bri[k], bsh[k], brm[k], 32'd0, bc[k]);
        end
        sent = 0;
        got  = 0;
        rs   = 32'd0;
        for (int i = 0; i < 40 && got < 4; i++) begin
            if (out_valid) begin
                if (q.size() == 0) chk("bp_duplicate", 64'(out_valid), 64'd0);
                else chk("bp_data", 64'({shifter_carry_out, shifter_operand}), 64'(q[0]));
            end
            out_ready = pat[i % 4][0];
            if (sent < 4) begin
                sel = bs[sent]; shift_type = bt[sent]; imm8 = bi8[sent]; rotate_imm = bri[sent];
                shift_imm = bsh[sent]; rm = brm[sent]; c_flag_in = bc[sent]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            chk("bp_in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
            acc = in_valid && (!out_valid || out_ready);
            ret = out_valid && out_ready;
            @(posedge clk);
            if (ret && q.size() > 0) begin
                void'(q.pop_front());
                got++;
            end
            if (acc) begin
                q.push_back(expv[sent]);
                sent++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("bp_retired_count", 64'(got), 64'd4);
        chk("bp_queue_empty", 64'(q.size()), 64'd0);

        // 16-bit instance with no extra register-shift cycle.
        sel_b = 2'd2; shift_type_b = 2'd2; rm_b = 16'h8000; rs_b = 16'd20; in_valid_b = 1'b1;
        @(negedge clk);
        in_valid_b = 1'b0;
        rm_b = 16'h0001;
        chk("w16_asr20_valid", 64'(out_valid_b), 64'd1);
        chk("w16_asr20_op", 64'(shifter_operand_b), 64'hFFFF);
        chk("w16_asr20_carry", 64'(shifter_carry_out_b), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
